// File: rtl/seg_capture.sv
// seg_capture: recovers hex digits from a multiplexed active-low 7-segment display bus.
// Optional macro SEG_CAPTURE_BLANK_EN makes an all-off digit (seg=7F) a valid blank sample.
module seg_capture #(
  parameter int unsigned SETTLE = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  seg,
  input  logic [3:0]  an,
  output logic [15:0] digits,
  output logic [3:0]  digit_valid,
  output logic        frame_valid,
  output logic        err,
  output logic [3:0]  blank
);

  localparam logic [7:0] SETTLE_CNT = 8'(SETTLE);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_HOLD
  } state_t;

  state_t      r_state;
  logic [7:0]  r_count;
  logic [3:0]  r_an;
  logic [6:0]  r_seg;
  logic [3:0]  r_an_p;
  logic [6:0]  r_seg_p;
  logic [15:0] r_digits;
  logic [3:0]  r_digit_valid;
  logic        r_frame_valid;
  logic        r_err;

  logic        w_one_hot;
  logic        w_changed;
  logic        w_sample;
  logic [1:0]  w_idx;
  logic [3:0]  w_dv_set;
  logic        w_dec_ok;
  logic [3:0]  w_dec_nib;
`ifdef SEG_CAPTURE_BLANK_EN
  logic        w_dec_blank;
  logic [3:0]  r_blank;
`endif

  // Digit select: exactly one anode driven low; index of that anode.
  // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    w_one_hot = 1'b0;
    w_idx     = 2'd0;
    case (r_an)
      4'b1110: begin w_one_hot = 1'b1; w_idx = 2'd0; end
      4'b1101: begin w_one_hot = 1'b1; w_idx = 2'd1; end
      4'b1011: begin w_one_hot = 1'b1; w_idx = 2'd2; end
      4'b0111: begin w_one_hot = 1'b1; w_idx = 2'd3; end
      default: begin w_one_hot = 1'b0; w_idx = 2'd0; end
    endcase
  end

  always_comb begin
    w_dec_ok  = 1'b1;
    w_dec_nib = 4'h0;
`ifdef SEG_CAPTURE_BLANK_EN
    w_dec_blank = 1'b0;
`endif
    case (r_seg)
      7'h40: w_dec_nib = 4'h0;
      7'h79: w_dec_nib = 4'h1;
      7'h24: w_dec_nib = 4'h2;
      7'h30: w_dec_nib = 4'h3;
      7'h19: w_dec_nib = 4'h4;
      7'h12: w_dec_nib = 4'h5;
      7'h02: w_dec_nib = 4'h6;
      7'h78: w_dec_nib = 4'h7;
      7'h00: w_dec_nib = 4'h8;
      7'h10: w_dec_nib = 4'h9;
      7'h08: w_dec_nib = 4'hA;
      7'h03: w_dec_nib = 4'hB;
      7'h46: w_dec_nib = 4'hC;
      7'h21: w_dec_nib = 4'hD;
      7'h06: w_dec_nib = 4'hE;
      7'h0E: w_dec_nib = 4'hF;
`ifdef SEG_CAPTURE_BLANK_EN
      7'h7F: w_dec_blank = 1'b1;
`endif
      default: w_dec_ok = 1'b0;
    endcase
  end

  assign w_changed = {r_an, r_seg} != {r_an_p, r_seg_p};
  assign w_sample  = (r_state == S_SETTLE) && !w_changed && (r_count >= SETTLE_CNT);
  assign w_dv_set  = r_digit_valid | (4'b0001 << w_idx);

  // NOTE: the input stage is reset to "no digit selected" so that after reset the
  // first sample always needs a full settle window of fresh input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_count       <= 8'd0;
      r_an          <= 4'hF;
      r_seg         <= 7'h7F;
      r_an_p        <= 4'hF;
      r_seg_p       <= 7'h7F;
      r_digits      <= 16'h0000;
      r_digit_valid <= 4'b0000;
      r_frame_valid <= 1'b0;
      r_err         <= 1'b0;
`ifdef SEG_CAPTURE_BLANK_EN
      r_blank       <= 4'b0000;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register sees pre-edge values.
      r_an          <= an;
      r_seg         <= seg;
      r_an_p        <= r_an;
      r_seg_p       <= r_seg;
      r_frame_valid <= 1'b0;
      r_err         <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (w_one_hot) begin
            r_state <= S_SETTLE;
            r_count <= 8'd1;
          end
        end
        S_SETTLE, S_HOLD: begin
          if (w_changed) begin
            if (w_one_hot) begin
              r_state <= S_SETTLE;
              r_count <= 8'd1;
            end else begin
              r_state <= S_IDLE;
              r_count <= 8'd0;
            end
          end else if (w_sample) begin
            r_state <= S_HOLD;
          end else if (r_state == S_SETTLE) begin
            r_count <= r_count + 8'd1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_count <= 8'd0;
        end
      endcase

      if (w_sample) begin
        if (!w_dec_ok) begin
          r_err <= 1'b1;
        end else begin
          r_digits[{w_idx, 2'b00} +: 4] <= w_dec_nib;
`ifdef SEG_CAPTURE_BLANK_EN
          r_blank[w_idx] <= w_dec_blank;
`endif
          if (w_dv_set == 4'b1111) begin
            r_frame_valid <= 1'b1;
            r_digit_valid <= 4'b0000;
          end else begin
            r_digit_valid <= w_dv_set;
          end
        end
      end
    end
  end

  assign digits      = r_digits;
  assign digit_valid = r_digit_valid;
  assign frame_valid = r_frame_valid;
  assign err         = r_err;
`ifdef SEG_CAPTURE_BLANK_EN
  assign blank       = r_blank;
`else
  assign blank       = 4'b0000;
`endif

endmodule

// File: tb/tb_seg_capture.sv
// Directed self-checking bench for seg_capture with SETTLE=4.
module tb_seg_capture;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [6:0]  seg = 7'h7F;
  logic [3:0]  an  = 4'hF;
  logic [15:0] digits;
  logic [3:0]  digit_valid;
  logic        frame_valid;
  logic        err;
  logic [3:0]  blank;

  int checks = 0;
  int errors = 0;
  int fv_cnt = 0;
  int err_cnt = 0;

  seg_capture #(.SETTLE(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .seg         (seg),
    .an          (an),
    .digits      (digits),
    .digit_valid (digit_valid),
    .frame_valid (frame_valid),
    .err         (err),
    .blank       (blank)
  );

  always #5 clk = ~clk;

  // Pulse counters, plus the standing rule that err and frame_valid are exclusive.
  always @(negedge clk) begin
    if (frame_valid === 1'b1) fv_cnt++;
    if (err === 1'b1) err_cnt++;
    if (!rst) begin
      checks++;
      if (frame_valid === 1'b1 && err === 1'b1) begin
        errors++;
        $display("FAIL err_and_frame: both high at %0t", $time);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] a, input logic [6:0] s, input int n);
    an  = a;
    seg = s;
    repeat (n) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    an  = 4'hF;
    seg = 7'h7F;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({digits, digit_valid, frame_valid, err, blank} !== 26'd0) begin
      errors++;
      $display("FAIL reset_state: got digits=%h dv=%b fv=%b err=%b blank=%b want all zero",
               digits, digit_valid, frame_valid, err, blank);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    logic early;
    int fv0, er0;
    do_reset();
    fv0 = fv_cnt; er0 = err_cnt;
    early = 1'b0;
    an = 4'b1110; seg = 7'h30;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (digit_valid !== 4'b0000) early = 1'b1;
    end
    checks++;
    if (early) begin
      errors++;
      $display("FAIL single_early: digit_valid set before 5 clocks, got %b want 0000", digit_valid);
    end
    tick();
    checks++;
    if (digit_valid !== 4'b0001) begin
      errors++;
      $display("FAIL single_dv: got %b want 0001", digit_valid);
    end
    checks++;
    if (digits !== 16'h0003) begin
      errors++;
      $display("FAIL single_digits: got %h want 0003", digits);
    end
    drive(4'hF, 7'h7F, 4);
    checks++;
    if (digit_valid !== 4'b0001 || digits !== 16'h0003 || fv_cnt != fv0 || err_cnt != er0) begin
      errors++;
      $display("FAIL single_once: dv=%b digits=%h fv=%0d err=%0d want 0001 0003 0 0",
               digit_valid, digits, fv_cnt - fv0, err_cnt - er0);
    end
  endtask

  task automatic test_frame();
    logic [3:0]  an_v  [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    logic [6:0]  seg_v [4] = '{7'h40, 7'h79, 7'h24, 7'h0E};
    logic [3:0]  dv_e  [4] = '{4'b0001, 4'b0011, 4'b0111, 4'b0000};
    logic [15:0] dig_e [4] = '{16'h0000, 16'h0010, 16'h0210, 16'hF210};
    int fv0;
    do_reset();
    fv0 = fv_cnt;
    for (int d = 0; d < 4; d++) begin
      drive(an_v[d], seg_v[d], 6);
      checks++;
      if (digit_valid !== dv_e[d] || digits !== dig_e[d]) begin
        errors++;
        $display("FAIL frame_step%0d: got dv=%b digits=%h want dv=%b digits=%h",
                 d, digit_valid, digits, dv_e[d], dig_e[d]);
      end
    end
    checks++;
    if (frame_valid !== 1'b1) begin
      errors++;
      $display("FAIL frame_pulse: got %b want 1", frame_valid);
    end
    tick();
    checks++;
    if (frame_valid !== 1'b0 || fv_cnt != fv0 + 1) begin
      errors++;
      $display("FAIL frame_once: fv=%b pulses=%0d want 0 and 1", frame_valid, fv_cnt - fv0);
    end
  endtask

  task automatic test_err();
    int er0;
    drive(4'b1110, 7'h79, 6);
    checks++;
    if (digit_valid !== 4'b0001 || digits !== 16'hF211) begin
      errors++;
      $display("FAIL err_pre: got dv=%b digits=%h want 0001 F211", digit_valid, digits);
    end
    er0 = err_cnt;
    drive(4'b1101, 7'h55, 6);
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL err_pulse: got %b want 1", err);
    end
    tick();
    checks++;
    if (err !== 1'b0 || err_cnt != er0 + 1 || digit_valid !== 4'b0001 || digits !== 16'hF211) begin
      errors++;
      $display("FAIL err_hold: err=%b pulses=%0d dv=%b digits=%h want 0 1 0001 F211",
               err, err_cnt - er0, digit_valid, digits);
    end
  endtask

  task automatic test_blank();
    int er0;
    er0 = err_cnt;
    drive(4'b1011, 7'h7F, 6);
`ifdef SEG_CAPTURE_BLANK_EN
    checks++;
    if (blank !== 4'b0100 || digit_valid !== 4'b0101 || digits !== 16'hF011 || err_cnt != er0) begin
      errors++;
      $display("FAIL blank_set: blank=%b dv=%b digits=%h errs=%0d want 0100 0101 F011 0",
               blank, digit_valid, digits, err_cnt - er0);
    end
    drive(4'b1011, 7'h24, 6);
    checks++;
    if (blank !== 4'b0000 || digits !== 16'hF211) begin
      errors++;
      $display("FAIL blank_clear: blank=%b digits=%h want 0000 F211", blank, digits);
    end
`else
    checks++;
    if (err !== 1'b1 || blank !== 4'b0000 || digit_valid !== 4'b0001 || digits !== 16'hF211) begin
      errors++;
      $display("FAIL blank_err: err=%b blank=%b dv=%b digits=%h want 1 0000 0001 F211",
               err, blank, digit_valid, digits);
    end
`endif
  endtask

  task automatic test_settle();
    int fv0, er0;
    do_reset();
    fv0 = fv_cnt; er0 = err_cnt;
    an = 4'b1110;
    for (int t = 0; t < 7; t++) begin
      seg = (t % 2 == 0) ? 7'h40 : 7'h79;
      repeat (3) tick();
    end
    checks++;
    if (digit_valid !== 4'b0000 || err_cnt != er0 || fv_cnt != fv0) begin
      errors++;
      $display("FAIL settle_toggle: dv=%b errs=%0d frames=%0d want 0000 0 0",
               digit_valid, err_cnt - er0, fv_cnt - fv0);
    end
    drive(4'b1110, 7'h79, 5);
    checks++;
    if (digit_valid !== 4'b0000) begin
      errors++;
      $display("FAIL settle_early: got dv=%b want 0000", digit_valid);
    end
    tick();
    checks++;
    if (digit_valid !== 4'b0001 || digits !== 16'h0001) begin
      errors++;
      $display("FAIL settle_hold: got dv=%b digits=%h want 0001 0001", digit_valid, digits);
    end
  endtask

  task automatic test_idle();
    int fv0, er0;
    do_reset();
    drive(4'b1110, 7'h30, 6);
    fv0 = fv_cnt; er0 = err_cnt;
    drive(4'b1111, 7'h30, 10);
    checks++;
    if (digit_valid !== 4'b0001 || digits !== 16'h0003 || fv_cnt != fv0 || err_cnt != er0) begin
      errors++;
      $display("FAIL idle_none: dv=%b digits=%h fv=%0d err=%0d want 0001 0003 0 0",
               digit_valid, digits, fv_cnt - fv0, err_cnt - er0);
    end
    drive(4'b1100, 7'h30, 10);
    checks++;
    if (digit_valid !== 4'b0001 || digits !== 16'h0003 || fv_cnt != fv0 || err_cnt != er0) begin
      errors++;
      $display("FAIL idle_multi: dv=%b digits=%h fv=%0d err=%0d want 0001 0003 0 0",
               digit_valid, digits, fv_cnt - fv0, err_cnt - er0);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive(4'b1110, 7'h79, 6);
    drive(4'b1101, 7'h24, 6);
    drive(4'b1011, 7'h30, 6);
    checks++;
    if (digit_valid !== 4'b0111 || digits !== 16'h0321) begin
      errors++;
      $display("FAIL rstmid_pre: got dv=%b digits=%h want 0111 0321", digit_valid, digits);
    end
    drive(4'b0111, 7'h0E, 3);
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({digits, digit_valid, frame_valid, err, blank} !== 26'd0) begin
      errors++;
      $display("FAIL rstmid_clear: digits=%h dv=%b fv=%b err=%b blank=%b want all zero",
               digits, digit_valid, frame_valid, err, blank);
    end
    @(negedge clk);
    #1 rst = 1'b0;
    repeat (5) tick();
    checks++;
    if (digit_valid !== 4'b0000) begin
      errors++;
      $display("FAIL rstmid_early: got dv=%b want 0000", digit_valid);
    end
    tick();
    checks++;
    if (digit_valid !== 4'b1000 || digits !== 16'hF000) begin
      errors++;
      $display("FAIL rstmid_sample: got dv=%b digits=%h want 1000 F000", digit_valid, digits);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_frame();
    test_err();
    test_blank();
    test_settle();
    test_idle();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
